// File: rtl/div_recon.sv
// Rebuilds a dividend as Q*DSR + R by shift-and-add, one multiplier bit per clock,
// then flags whether it equals the expected dividend and whether R is a legal remainder.
module div_recon #(
  parameter int unsigned W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [W-1:0]     DSR,
  input  logic [W-1:0]     Q,
  input  logic [W-1:0]     R,
  input  logic [2*W-1:0]   EXP_DVD,
  output logic             BUSY,
  output logic             DONE,
  output logic [2*W-1:0]   DVD,
  output logic             MATCH,
  output logic             RERR
);

  localparam int unsigned DW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;
  logic [DW-1:0] mcand_q;
  logic [DW-1:0] exp_q;
  logic [DW-1:0] dvd_q;
  logic [W-1:0]  mplier_q;
  logic [W-1:0]  dsr_q;
  logic [W-1:0]  r_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          match_q;
  logic          rerr_q;

  // Conditional add of the shifted multiplicand; 2W bits cannot overflow.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      exp_q    <= '0;
      dvd_q    <= '0;
      mplier_q <= '0;
      dsr_q    <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            acc_q    <= {{W{1'b0}}, R};
            mcand_q  <= {{W{1'b0}}, DSR};
            mplier_q <= Q;
            cnt_q    <= CW'(W);
            exp_q    <= EXP_DVD;
            dsr_q    <= DSR;
            r_q      <= R;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        // Fixed W steps regardless of remaining multiplier bits.
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          dvd_q   <= acc_q;
          match_q <= (acc_q == exp_q);
          rerr_q  <= (dsr_q == '0) || (r_q >= dsr_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign DVD   = dvd_q;
  assign MATCH = match_q;
  assign RERR  = rerr_q;

endmodule
